// File: rtl/reg_bank4x16_pkg.sv
// rtl/reg_bank4x16_pkg.sv - shared width default, index type and pointer helper for reg_bank4x16
package reg_bank4x16_pkg;

    localparam int WIDTH_DEFAULT = 16;
    localparam int DEPTH_FIXED   = 4;

    typedef logic [1:0] idx_t;

    // Natural 2-bit overflow gives the 3->0 wrap of the scan pointer.
    function automatic idx_t next_idx(input idx_t i);
        return i + idx_t'(1);
    endfunction

endpackage

// File: rtl/mux4way16.sv
// rtl/mux4way16.sv - four-input WIDTH-bit combinational selector
module mux4way16
    import reg_bank4x16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  idx_t             sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = a;
        case (sel)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            2'd3:    y = d;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/reg_bank4x16.sv
// rtl/reg_bank4x16.sv - four-entry register bank with direct or auto-scan read select
module reg_bank4x16
    import reg_bank4x16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_FIXED
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  idx_t             waddr,
    input  logic [WIDTH-1:0] wdata,
    input  idx_t             raddr,
    input  logic             scan_en,
    output logic [WIDTH-1:0] rdata,
    output idx_t             rsel,
    output logic             scan_last
);

    logic [WIDTH-1:0] regs [DEPTH];
    idx_t             scan_ptr;

    // Reset wins over both the write and the pointer increment on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            scan_ptr <= '0;
        end else begin
            if (we) begin
                regs[waddr] <= wdata;
            end
            if (scan_en) begin
                scan_ptr <= next_idx(scan_ptr);
            end
        end
    end

    assign rsel      = scan_en ? scan_ptr : raddr;
    assign scan_last = scan_en && (scan_ptr == idx_t'(3));

    // Read is purely from stored state, so a same-cycle write is not visible until after the edge.
    mux4way16 #(
        .WIDTH (WIDTH)
    ) u_rd_mux (
        .a   (regs[0]),
        .b   (regs[1]),
        .c   (regs[2]),
        .d   (regs[3]),
        .sel (rsel),
        .y   (rdata)
    );

endmodule

// File: tb/tb_reg_bank4x16.sv
// tb/tb_reg_bank4x16.sv - self-checking bench for reg_bank4x16 with behavioural model
module tb_reg_bank4x16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [1:0]  waddr = '0;
    logic [15:0] wdata = '0;
    logic [1:0]  raddr = '0;
    logic        scan_en = 1'b0;
    logic [15:0] rdata;
    logic [1:0]  rsel;
    logic        scan_last;

    int n_cmp = 0;
    int n_fail = 0;
    logic check_en = 1'b0;

    logic [15:0] m_r [4] = '{default: 16'h0};
    int          m_ptr = 0;

    always #5 clk = ~clk;

    reg_bank4x16 #(.WIDTH(16), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr     (raddr),
        .scan_en   (scan_en),
        .rdata     (rdata),
        .rsel      (rsel),
        .scan_last (scan_last)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: four registers and a modulo-4 pointer updated on each edge.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) m_r[i] <= 16'h0;
            m_ptr <= 0;
        end else begin
            if (we) m_r[waddr] <= wdata;
            if (scan_en) m_ptr <= (m_ptr + 1) % 4;
        end
    end

    always @(negedge clk) begin
        int sel;
        if (check_en) begin
            sel = scan_en ? m_ptr : int'(raddr);
            chk("model_rsel", 32'(rsel), 32'(sel));
            chk("model_rdata", 32'(rdata), 32'(m_r[sel]));
            chk("model_scan_last", 32'(scan_last), 32'(scan_en && m_ptr == 3));
        end
    end

    task automatic cyc(input logic r, input logic w, input logic [1:0] wa,
                       input logic [15:0] wd, input logic [1:0] ra, input logic se);
        @(posedge clk);
        #1;
        reset = r; we = w; waddr = wa; wdata = wd; raddr = ra; scan_en = se;
        #1;
    endtask

    logic [15:0] vals [4] = '{16'hAAAA, 16'h5555, 16'h0F0F, 16'hF0F0};
    logic [1:0]  exp_seq [3] = '{2'd2, 2'd3, 2'd0};

    initial begin
        cyc(1'b1, 1'b0, 2'd0, 16'h0, 2'd0, 1'b0);
        cyc(1'b1, 1'b0, 2'd0, 16'h0, 2'd0, 1'b0);
        check_en = 1'b1;

        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 2'd0, 16'h0, 2'(i), 1'b0);
            chk("reset_rdata", 32'(rdata), 32'h0);
            chk("reset_scan_last", 32'(scan_last), 32'h0);
        end

        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 2'(i), vals[i], 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 2'd0, 16'h0, 2'(i), 1'b0);
            chk("load_rdata", 32'(rdata), 32'(vals[i]));
        end

        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, 2'd0, 16'h0, 2'd0, 1'b1);
            chk("scan_rsel", 32'(rsel), 32'(i % 4));
            chk("scan_rdata", 32'(rdata), 32'(vals[i % 4]));
            chk("scan_last", 32'(scan_last), 32'((i % 4) == 3));
        end

        cyc(1'b0, 1'b1, 2'd2, 16'h1234, 2'd2, 1'b0);
        chk("wr_before_edge", 32'(rdata), 32'h0F0F);
        cyc(1'b0, 1'b0, 2'd0, 16'h0, 2'd2, 1'b0);
        chk("wr_after_edge", 32'(rdata), 32'h1234);

        for (int j = 0; j < 3; j++) begin
            cyc(1'b0, 1'b0, 2'd0, 16'h0, 2'(j + 1), 1'b0);
            chk("hold_rsel_raddr", 32'(rsel), 32'(j + 1));
        end
        for (int j = 0; j < 3; j++) begin
            cyc(1'b0, 1'b0, 2'd0, 16'h0, 2'd0, 1'b1);
            chk("resume_rsel", 32'(rsel), 32'(exp_seq[j]));
        end
        cyc(1'b0, 1'b0, 2'd0, 16'h0, 2'd0, 1'b1);
        chk("advance_rsel", 32'(rsel), 32'd1);
        cyc(1'b0, 1'b0, 2'd0, 16'h0, 2'd0, 1'b1);
        chk("advance_rsel", 32'(rsel), 32'd2);

        cyc(1'b1, 1'b1, 2'd1, 16'hFFFF, 2'd0, 1'b1);
        chk("pre_reset_rsel", 32'(rsel), 32'd3);
        chk("pre_reset_scan_last", 32'(scan_last), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 2'd0, 16'h0, 2'(i), 1'b0);
            chk("post_reset_rdata", 32'(rdata), 32'h0);
        end
        cyc(1'b0, 1'b0, 2'd0, 16'h0, 2'd0, 1'b1);
        chk("post_reset_ptr", 32'(rsel), 32'd0);
        chk("post_reset_scan_last", 32'(scan_last), 32'd0);

        for (int k = 0; k < 400; k++) begin
            cyc($urandom_range(0, 31) == 0, 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), 16'($urandom),
                2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0);
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_bank4x16.md
REG_BANK4X16 -- requirements
Module: reg_bank4x16

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data width of each register and of rdata.
REQ-002 The block SHALL have parameter DEPTH, default 4, fixed at 4; any other value is unsupported.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  is the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port we  input  1  is the write enable.
REQ-006 Port waddr  input  2  is the write register index.
REQ-007 Port wdata  input  WIDTH  is the write data.
REQ-008 Port raddr  input  2  is the read index used when scan_en=0.
REQ-009 Port scan_en  input  1  selects auto-scan read mode.
REQ-010 Port rdata  output  WIDTH  is the selected register contents.
REQ-011 Port rsel  output  2  is the effective read select currently applied.
REQ-012 Port scan_last  output  1  is high while scanning with the scan pointer at 3.

Function
REQ-013 The block SHALL hold four WIDTH-bit registers r0..r3.
REQ-014 On a rising edge with we=1 and reset=0, register r[waddr] SHALL load wdata; the other registers hold.
REQ-015 rdata SHALL be combinational from state: rdata = r[rsel], zero-cycle latency after rsel settles.
REQ-016 rsel SHALL equal raddr when scan_en=0 and the 2-bit scan pointer when scan_en=1.
REQ-017 The scan pointer SHALL increment by 1 on every rising edge with scan_en=1, wrapping 3->0.
REQ-018 The scan pointer SHALL hold its value on edges with scan_en=0; re-enabling scan resumes from the held value.
REQ-019 scan_last SHALL equal scan_en AND (pointer == 3), combinationally.
REQ-020 A write to the register currently selected by rsel SHALL show the old value on rdata until the edge, and the new value after it; there is no write-through bypass.
REQ-021 Simultaneous write and scan SHALL operate independently; the pointer advances and the write completes on the same edge.
REQ-022 Writes to all four indices SHALL be accepted with no back-pressure; one write per cycle maximum.

Reset
REQ-023 With reset=1 on a rising edge, r0..r3 SHALL become 0 and the scan pointer SHALL become 0, overriding any concurrent write or increment.
REQ-024 Following reset, rdata SHALL read 0 for every rsel, and scan_last SHALL be 0.
REQ-025 Reset asserted mid-scan SHALL restart scanning from index 0 on the first non-reset edge with scan_en=1.

Structure
REQ-026 A shared package SHALL hold the WIDTH default (16) and the 2-bit index type used by waddr, raddr, rsel and the pointer.
REQ-027 The read path SHALL instantiate the existing mux4way16 as its one sub-module, with a=r0, b=r1, c=r2, d=r3, sel=rsel, y=rdata.
REQ-028 The block SHALL contain no latches; all storage is edge-triggered on clk.

Verification
REQ-029 Reset, then raddr swept 0..3 with scan_en=0 -> rdata=0000 each time, scan_last=0.
REQ-030 Write r0=AAAA, r1=5555, r2=0F0F, r3=F0F0 over four cycles, then raddr 0,1,2,3 -> rdata AAAA, 5555, 0F0F, F0F0.
REQ-031 scan_en=1 for 6 cycles from pointer 0 -> rsel 0,1,2,3,0,1; rdata follows the loaded values; scan_last high only in the rsel=3 cycle.
REQ-032 raddr=2, we=1, waddr=2, wdata=1234 -> rdata=0F0F before the edge, 1234 after it.
REQ-033 Scan to pointer=2, drop scan_en for 3 cycles, re-enable -> rsel shows raddr while disabled, then resumes 2,3,0.
REQ-034 Assert reset with we=1, waddr=1, wdata=FFFF, scan_en=1 at pointer=3 -> all registers 0000, pointer 0, no write to r1.
